uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
//
// PURPOSE
// - Receive-side elastic buffer directly downstream of the UART receiver.
// - Captures each received byte on its 1-cycle data_valid pulse (no backpressure is possible on that side)
//   and presents bytes to the consumer over a valid/ready handshake, first-word-fall-through.
// - Counts and flags bytes lost to overflow so software/bench can detect dropped characters.
//
// PARAMETERS
// - DEPTH     16  number of byte entries; power of two, >= 2
// - AFULL_LVL 12  level at/above which almost_full asserts; 1..DEPTH
//
// PORTS
// - clk            in   1         system clock (same clock as the UART receiver)
// - rst_n          in   1         asynchronous, active-low reset
// - in_data        in   8         received byte; sampled only when in_valid=1
// - in_valid       in   1         1-cycle push strobe from receiver; may arrive every cycle
// - out_data       out  8         head-of-queue byte; meaningful only when out_valid=1
// - out_valid      out  1         queue non-empty
// - out_ready      in   1         consumer accepts out_data; pop occurs when out_valid & out_ready
// - level          out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
// - almost_full    out  1         level >= AFULL_LVL
// - overflow       out  1         sticky: a push was dropped since last clear
// - overflow_clear in   1         1-cycle clear of overflow and drop_count
// - drop_count     out  8         number of dropped bytes, saturates at 8'hFF
//
// BEHAVIOUR
// - Reset (rst_n=0, async assert, sync deassert upstream): wr/rd pointers=0, level=0, out_valid=0,
//   almost_full=0 (AFULL_LVL>=1), overflow=0, drop_count=0. Storage contents not reset; out_data is don't-care.
// - Pointers: ADDR_W=$clog2(DEPTH) bits + 1 wrap bit; natural wrap-around at DEPTH, no special case.
// - empty = (wr_ptr == rd_ptr); full = addresses equal and wrap bits differ. level = wr_ptr - rd_ptr (modular).
// - push = in_valid & (~full | pop); pop = out_valid & out_ready.
// - Push: mem[wr_ptr] <= in_data, wr_ptr++ at the clock edge.
// - Pop: rd_ptr++ at the clock edge; out_data = mem[rd_ptr] combinationally (FWFT).
// - Latency: byte pushed at edge N into empty FIFO -> out_valid=1 and out_data valid in the cycle after edge N.
//   No same-cycle bypass from in_data to out_data.
// - Simultaneous push+pop: both take effect, level unchanged; legal when full (no drop) and when empty is
//   impossible (pop needs out_valid=1).
// - Full & in_valid & ~pop: byte dropped, storage/pointers unchanged, overflow<=1, drop_count++ (saturating).
// - overflow_clear & drop in same cycle: drop wins -> overflow=1, drop_count=1.
// - out_ready while out_valid=0: ignored, no pointer movement.
// - out_valid, level, almost_full are derived from registered pointers only (no combinational path from
//   in_valid/out_ready to any output).
// - Reset asserted mid-stream: all queued bytes discarded immediately; out_valid falls asynchronously.
//
// STRUCTURE
// - uart_pkg (shared): UART_DATA_W=8, typedef logic [UART_DATA_W-1:0] uart_byte_t; in_data/out_data use it.
// - Single module: pointer/flag logic plus inline register-array storage; no sub-module needed.
// - Elaboration-time checks: DEPTH power of two >= 2; 1 <= AFULL_LVL <= DEPTH.
//
// TESTING
// - Reset, then push 8'hA5 with out_ready=0 -> next cycle out_valid=1, out_data=8'hA5, level=1.
// - Push 16 bytes 8'h00..8'h0F back-to-back, out_ready=0 -> level=16, almost_full=1 from level 12, pop all
//   -> exact order 00..0F, then out_valid=0, level=0.
// - Full FIFO, 3 more pushes without pop -> bytes dropped, overflow=1, drop_count=3, contents unchanged;
//   overflow_clear -> overflow=0, drop_count=0.
// - Full FIFO, push 8'h5A with out_ready=1 same cycle -> no drop, level stays 16, 8'h5A emerges last.
// - 300 pushes into full FIFO -> drop_count saturates at 8'hFF; clear coincident with drop -> drop_count=1.
// - Random push/pop for 10k cycles, pointers wrapping many times -> scoreboard matches, level never > DEPTH;
//   rst_n pulsed mid-stream -> out_valid=0, level=0 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART data width and byte type
package uart_pkg;
  localparam int UART_DATA_W = 8;
  typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through byte FIFO behind the UART receiver with overflow accounting
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AFULL_LVL = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  uart_byte_t              in_data,
  input  logic                    in_valid,
  output uart_byte_t              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    almost_full,
  output logic                    overflow,
  input  logic                    overflow_clear,
  output logic [7:0]              drop_count
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
  end
  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_afull_chk
    $error("uart_rx_fifo: AFULL_LVL must be within 1..DEPTH");
  end

  logic [AW:0] wr_ptr, rd_ptr;
  uart_byte_t  mem [DEPTH];
  logic        full, push, pop, drop;

  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign out_valid   = wr_ptr != rd_ptr;
  assign level       = wr_ptr - rd_ptr;
  assign almost_full = level >= (AW + 1)'(AFULL_LVL);
  assign out_data    = mem[rd_ptr[AW-1:0]];
  assign pop         = out_valid & out_ready;
  assign push        = in_valid & (~full | pop);
  assign drop        = in_valid & full & ~pop;

  // Storage is not reset; a slot is only read once a push has filled it.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;

  // Pointers wrap naturally; a drop leaves them and the storage untouched.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
    end

  // Overflow accounting: a drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      overflow   <= drop | (overflow & ~overflow_clear);
      drop_count <= drop ? (overflow_clear ? 8'd1 : (&drop_count ? drop_count : drop_count + 8'd1))
                         : (overflow_clear ? 8'd0 : drop_count);
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and scoreboarded checks of the UART receive FIFO
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  uart_byte_t in_data = '0;
  logic       in_valid = 1'b0;
  uart_byte_t out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [4:0] level;
  logic       almost_full;
  logic       overflow;
  logic       overflow_clear = 1'b0;
  logic [7:0] drop_count;

  int n_chk = 0;
  int n_fail = 0;

  uart_rx_fifo #(.DEPTH(16), .AFULL_LVL(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .almost_full(almost_full), .overflow(overflow),
    .overflow_clear(overflow_clear), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] base);
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = base + 8'(i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input logic [7:0] base, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (out_data !== base + 8'(i) || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL drain[%0d]: got valid=%b data=%h, want valid=1 data=%h", i, out_valid, out_data, base + 8'(i));
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({out_valid, level, almost_full, overflow, drop_count} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset: got valid=%b level=%0d af=%b ovf=%b drops=%0d, want all 0",
               out_valid, level, almost_full, overflow, drop_count);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL ready_when_empty: got valid=%b level=%0d, want 0 0", out_valid, level);
    end
  endtask

  task automatic test_single;
    in_data = 8'hA5;
    in_valid = 1'b1;
    #1;
    n_chk++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL no_bypass: got valid=%b, want 0", out_valid);
    end
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || level !== 5'd1) begin
      n_fail++;
      $display("FAIL single_push: got valid=%b data=%h level=%0d, want 1 a5 1", out_valid, out_data, level);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL single_pop: got valid=%b level=%0d, want 0 0", out_valid, level);
    end
  endtask

  task automatic test_fill_drain;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i);
      tick();
      n_chk++;
      if (level !== 5'(i + 1) || almost_full !== (i + 1 >= 12)) begin
        n_fail++;
        $display("FAIL fill_level[%0d]: got level=%0d af=%b, want level=%0d af=%b",
                 i, level, almost_full, i + 1, (i + 1 >= 12));
      end
    end
    in_valid = 1'b0;
    drain(8'h00, 16);
    n_chk++;
    if (out_valid !== 1'b0 || level !== 5'd0 || almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL drained: got valid=%b level=%0d af=%b, want 0 0 0", out_valid, level, almost_full);
    end
  endtask

  task automatic test_overflow;
    fill(8'h40);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hE0 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    n_chk++;
    if (overflow !== 1'b1 || drop_count !== 8'd3 || level !== 5'd16) begin
      n_fail++;
      $display("FAIL overflow: got ovf=%b drops=%0d level=%0d, want 1 3 16", overflow, drop_count, level);
    end
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    n_chk++;
    if (overflow !== 1'b0 || drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL overflow_clear: got ovf=%b drops=%0d, want 0 0", overflow, drop_count);
    end
    drain(8'h40, 16);
  endtask

  task automatic test_full_push_pop;
    fill(8'h10);
    in_data = 8'h5A;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_chk++;
    if (level !== 5'd16 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL full_push_pop: got level=%0d ovf=%b drops=%0d, want 16 0 0", level, overflow, drop_count);
    end
    drain(8'h11, 15);
    n_chk++;
    if (out_data !== 8'h5A || out_valid !== 1'b1 || level !== 5'd1) begin
      n_fail++;
      $display("FAIL full_push_pop_last: got valid=%b data=%h level=%0d, want 1 5a 1", out_valid, out_data, level);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_saturate;
    fill(8'h80);
    in_valid = 1'b1;
    in_data = 8'hFF;
    repeat (300) tick();
    n_chk++;
    if (drop_count !== 8'hFF || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate: got drops=%h ovf=%b, want ff 1", drop_count, overflow);
    end
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    in_valid = 1'b0;
    n_chk++;
    if (drop_count !== 8'd1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_with_drop: got drops=%0d ovf=%b, want 1 1", drop_count, overflow);
    end
    overflow_clear = 1'b1;
    tick();
    overflow_clear = 1'b0;
    drain(8'h80, 16);
  endtask

  task automatic test_random;
    logic [7:0] q[$];
    logic       pop, push;
    int         thr;
    for (int c = 0; c < 10000; c++) begin
      thr = ((c / 500) % 2 == 0) ? 75 : 35;
      n_chk++;
      if (out_valid !== (q.size() != 0) || level !== 5'(q.size()) || level > 5'd16 ||
          (q.size() != 0 && out_data !== q[0])) begin
        n_fail++;
        $display("FAIL random[%0d]: got valid=%b level=%0d data=%h, want valid=%b level=%0d data=%h",
                 c, out_valid, level, out_data, q.size() != 0, q.size(), q.size() != 0 ? q[0] : 8'h00);
      end
      in_valid = $urandom_range(0, 99) < thr;
      out_ready = $urandom_range(0, 99) < 55;
      in_data = 8'($urandom);
      pop = (q.size() != 0) && out_ready;
      push = in_valid && (q.size() < 16 || pop);
      tick();
      if (pop) void'(q.pop_front());
      if (push) q.push_back(in_data);
    end
    in_valid = 1'b1;
    out_ready = 1'b0;
    repeat (4) tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL midstream_reset: got valid=%b level=%0d, want 0 0", out_valid, level);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || level !== 5'd0 || drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL after_reset: got valid=%b level=%0d drops=%0d, want 0 0 0", out_valid, level, drop_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
